// File: rtl/operand_issue_if.sv
// Bundle of issue, writeback, register-file and operand signals around operand_issue.
// The slave view is the unit itself; the master view is its surrounding pipeline.
interface operand_issue_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [31:0] rf_val_rs1;
  logic [31:0] rf_val_rs2;
  logic [4:0]  rf_rd;
  logic [31:0] rf_val_rd;
  logic        rf_write_enable;
  logic        op_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic        op_rd_we;
  logic        sb_err;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    input  wb_valid, wb_rd, wb_val,
    input  rf_val_rs1, rf_val_rs2,
    output issue_ready,
    output rf_rs1, rf_rs2, rf_rd, rf_val_rd, rf_write_enable,
    output op_valid, op_a, op_b, op_rd, op_rd_we, sb_err
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    output wb_valid, wb_rd, wb_val,
    output rf_val_rs1, rf_val_rs2,
    input  issue_ready,
    input  rf_rs1, rf_rs2, rf_rd, rf_val_rd, rf_write_enable,
    input  op_valid, op_a, op_b, op_rd, op_rd_we, sb_err
  );
endinterface

// File: rtl/operand_issue.sv
// Operand fetch with a per-register in-flight scoreboard: stalls RAW hazards, drives the
// register-file ports and forwards a writeback that collides with the operand read.
module operand_issue #(
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  operand_issue_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MAX_INFLIGHT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r [1:31];
  logic [CNT_W-1:0] cnt_s [0:31];
  logic [31:0]      wb_hit_s;
  logic [31:1]      inc_s;
  logic [31:1]      dec_s;
  logic             rs1_ready_s;
  logic             rs2_ready_s;
  logic             rd_ready_s;
  logic             issue_ready_s;
  logic             accept_s;
  logic             wb_spurious_s;

  logic             op_valid_r;
  logic [4:0]       op_rd_r;
  logic             op_rd_we_r;
  logic             fwd_a_r;
  logic             fwd_b_r;
  logic [31:0]      fwd_a_val_r;
  logic [31:0]      fwd_b_val_r;
  logic [31:0]      held_a_r;
  logic [31:0]      held_b_r;
  logic             sb_err_r;
  logic [31:0]      op_a_s;
  logic [31:0]      op_b_s;

  function automatic logic src_ready(input logic [4:0] r, input logic [CNT_W-1:0] c,
                                     input logic hit);
    return (r == 5'd0) || (c == CNT_ZERO) || ((c == CNT_ONE) && hit);
  endfunction

  function automatic logic dst_ready(input logic we, input logic [4:0] r,
                                     input logic [CNT_W-1:0] c, input logic hit);
    return !we || (r == 5'd0) || (c < MAX_INFLIGHT) || hit;
  endfunction

  // Scoreboard view (x0 reads as never pending), hazard checks and counter steering
  always_comb begin
    cnt_s[0] = CNT_ZERO;
    for (int i = 1; i < 32; i++) begin
      cnt_s[i] = cnt_r[i];
    end
    wb_hit_s = 32'd0;
    if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
      wb_hit_s[bus.wb_rd] = 1'b1;
    end else begin
      wb_hit_s = 32'd0;
    end
    rs1_ready_s   = src_ready(bus.issue_rs1, cnt_s[bus.issue_rs1], wb_hit_s[bus.issue_rs1]);
    rs2_ready_s   = src_ready(bus.issue_rs2, cnt_s[bus.issue_rs2], wb_hit_s[bus.issue_rs2]);
    rd_ready_s    = dst_ready(bus.issue_rd_we, bus.issue_rd, cnt_s[bus.issue_rd],
                              wb_hit_s[bus.issue_rd]);
    issue_ready_s = !reset && rs1_ready_s && rs2_ready_s && rd_ready_s;
    accept_s      = bus.issue_valid && issue_ready_s;
    wb_spurious_s = bus.wb_valid && (bus.wb_rd != 5'd0) && (cnt_s[bus.wb_rd] == CNT_ZERO);
    for (int i = 1; i < 32; i++) begin
      inc_s[i] = accept_s && bus.issue_rd_we && (bus.issue_rd == 5'(i));
      dec_s[i] = wb_hit_s[i] && (cnt_r[i] != CNT_ZERO);
    end
  end

  // In-flight counters: simultaneous issue and retire of the same register cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_s[i] && !inc_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Operand stage registers, forward capture and sticky scoreboard error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid_r  <= 1'b0;
      op_rd_r     <= 5'd0;
      op_rd_we_r  <= 1'b0;
      fwd_a_r     <= 1'b0;
      fwd_b_r     <= 1'b0;
      fwd_a_val_r <= 32'd0;
      fwd_b_val_r <= 32'd0;
      held_a_r    <= 32'd0;
      held_b_r    <= 32'd0;
      sb_err_r    <= 1'b0;
    end else begin
      op_valid_r <= accept_s;
      if (accept_s) begin
        op_rd_r     <= bus.issue_rd;
        op_rd_we_r  <= bus.issue_rd_we && (bus.issue_rd != 5'd0);
        fwd_a_r     <= wb_hit_s[bus.issue_rs1];
        fwd_b_r     <= wb_hit_s[bus.issue_rs2];
        fwd_a_val_r <= bus.wb_val;
        fwd_b_val_r <= bus.wb_val;
      end else begin
        op_rd_r     <= op_rd_r;
        op_rd_we_r  <= op_rd_we_r;
        fwd_a_r     <= fwd_a_r;
        fwd_b_r     <= fwd_b_r;
        fwd_a_val_r <= fwd_a_val_r;
        fwd_b_val_r <= fwd_b_val_r;
      end
      // Latch delivered operands so they stay stable once the read data moves on
      if (op_valid_r) begin
        held_a_r <= op_a_s;
        held_b_r <= op_b_s;
      end else begin
        held_a_r <= held_a_r;
        held_b_r <= held_b_r;
      end
      if (wb_spurious_s) begin
        sb_err_r <= 1'b1;
      end else begin
        sb_err_r <= sb_err_r;
      end
    end
  end

  // Operand select: forwarded writeback wins over the register file's pre-write data
  always_comb begin
    if (!op_valid_r) begin
      op_a_s = held_a_r;
      op_b_s = held_b_r;
    end else begin
      op_a_s = fwd_a_r ? fwd_a_val_r : bus.rf_val_rs1;
      op_b_s = fwd_b_r ? fwd_b_val_r : bus.rf_val_rs2;
    end
  end

  assign bus.issue_ready     = issue_ready_s;
  assign bus.rf_rs1          = bus.issue_rs1;
  assign bus.rf_rs2          = bus.issue_rs2;
  assign bus.rf_rd           = bus.wb_rd;
  assign bus.rf_val_rd       = bus.wb_val;
  assign bus.rf_write_enable = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign bus.op_valid        = op_valid_r;
  assign bus.op_a            = op_a_s;
  assign bus.op_b            = op_b_s;
  assign bus.op_rd           = op_rd_r;
  assign bus.op_rd_we        = op_rd_we_r;
  assign bus.sb_err          = sb_err_r;

endmodule

// File: tb/tb_operand_issue.sv
// Table-driven bench for operand_issue with a behavioural register file and an
// expected-operand queue filled on accept and drained when op_valid appears.
module tb_operand_issue;

  logic clk = 1'b0;
  logic reset;
  operand_issue_if bus ();

  operand_issue #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file: 1-cycle read returning pre-write data, x0 reads zero
  logic [31:0] rf_mem [0:31];
  logic [31:0] rf_q1;
  logic [31:0] rf_q2;
  logic        rf_loaded = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'd7;
    if (i == 2) return 32'd9;
    if (i == 0) return 32'd0;
    return 32'h100 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      rf_loaded <= 1'b1;
    end else if (bus.rf_write_enable) begin
      rf_mem[bus.rf_rd] <= bus.rf_val_rd;
    end
    rf_q1 <= (bus.rf_rs1 == 5'd0) ? 32'd0 : rf_mem[bus.rf_rs1];
    rf_q2 <= (bus.rf_rs2 == 5'd0) ? 32'd0 : rf_mem[bus.rf_rs2];
  end

  assign bus.rf_val_rs1 = rf_q1;
  assign bus.rf_val_rs2 = rf_q2;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wval;
    logic        exp_ready;
    logic        exp_sb;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] arch_val(input logic [4:0] r, input logic wv,
                                           input logic [4:0] wrd, input logic [31:0] wval);
    if (r == 5'd0) return 32'd0;
    if (wv && (wrd == r)) return wval;
    return rf_mem[r];
  endfunction

  // One cycle: drive at negedge, check combinational ready, then check outputs after the edge
  task automatic step(input vec_t t, input string name);
    logic acc;
    exp_t e;
    bus.issue_valid = t.v;
    bus.issue_rs1   = t.rs1;
    bus.issue_rs2   = t.rs2;
    bus.issue_rd    = t.rd;
    bus.issue_rd_we = t.we;
    bus.wb_valid    = t.wv;
    bus.wb_rd       = t.wrd;
    bus.wb_val      = t.wval;
    #1;
    chk({name, ".ready"}, 32'(bus.issue_ready), 32'(t.exp_ready));
    chk({name, ".rf_we"}, 32'(bus.rf_write_enable), 32'(t.wv && (t.wrd != 5'd0)));
    acc = t.v && bus.issue_ready;
    if (acc) begin
      e.a     = arch_val(t.rs1, t.wv, t.wrd, t.wval);
      e.b     = arch_val(t.rs2, t.wv, t.wrd, t.wval);
      e.rd    = t.rd;
      e.rd_we = t.we && (t.rd != 5'd0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({name, ".op_valid"}, 32'(bus.op_valid), 32'(acc));
    chk({name, ".sb_err"}, 32'(bus.sb_err), 32'(t.exp_sb));
    if (bus.op_valid) begin
      if (exp_q.size() == 0) begin
        chk({name, ".unexpected_op"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({name, ".op_a"}, bus.op_a, e.a);
        chk({name, ".op_b"}, bus.op_b, e.b);
        chk({name, ".op_rd"}, 32'(bus.op_rd), 32'(e.rd));
        chk({name, ".op_rd_we"}, 32'(bus.op_rd_we), 32'(e.rd_we));
        last_a = e.a;
        last_b = e.b;
      end
    end else begin
      chk({name, ".hold_a"}, bus.op_a, last_a);
      chk({name, ".hold_b"}, bus.op_b, last_b);
    end
    @(negedge clk);
  endtask

  vec_t tbl [14];
  vec_t t;

  initial begin
    //           v     rs1   rs2   rd     we    wv    wrd   wval          rdy   sb
    tbl[0]  = '{1'b1, 5'd1, 5'd2, 5'd5,  1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[1]  = '{1'b1, 5'd3, 5'd4, 5'd6,  1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd5, 5'd1, 5'd8,  1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd5, 5'd1, 5'd8,  1'b0, 1'b1, 5'd5, 32'h1234,     1'b1, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 5'd6, 32'h66,       1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd0, 5'd0, 5'd0,  1'b1, 1'b1, 5'd0, 32'hdead,     1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd1, 5'd2, 5'd7,  1'b1, 1'b1, 5'd7, 32'h77,       1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd7, 5'd6, 5'd10, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 5'd9, 32'h99,       1'b1, 1'b1};
    tbl[13] = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1};

    reset           = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rs1   = 5'd0;
    bus.issue_rs2   = 5'd0;
    bus.issue_rd    = 5'd0;
    bus.issue_rd_we = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_val      = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.ready", 32'(bus.issue_ready), 32'd0);
    chk("reset.op_valid", 32'(bus.op_valid), 32'd0);
    chk("reset.op_a", bus.op_a, 32'd0);
    chk("reset.op_b", bus.op_b, 32'd0);
    chk("reset.op_rd", 32'(bus.op_rd), 32'd0);
    chk("reset.sb_err", 32'(bus.sb_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset while x5 is pending and a reader of x5 is stalled
    t = '{1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1};
    step(t, "pend5");
    bus.issue_valid = 1'b1;
    bus.issue_rs1   = 5'd5;
    bus.issue_rs2   = 5'd0;
    bus.issue_rd    = 5'd0;
    bus.issue_rd_we = 1'b0;
    bus.wb_valid    = 1'b0;
    #1;
    chk("midrst.stall", 32'(bus.issue_ready), 32'd0);
    chk("midrst.op_valid_before", 32'(bus.op_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst.ready", 32'(bus.issue_ready), 32'd0);
    chk("midrst.op_valid", 32'(bus.op_valid), 32'd0);
    chk("midrst.op_a", bus.op_a, 32'd0);
    chk("midrst.sb_err", 32'(bus.sb_err), 32'd0);
    bus.issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_a = 32'd0;
    last_b = 32'd0;
    t = '{1'b1, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
    step(t, "post_rst_read5");
    t = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h700, 1'b1, 1'b1};
    step(t, "stale_wb7");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand-fetch and scoreboard unit on the read side of the pipeline register file (1-cycle synchronous read, synchronous write, x0 hard-wired to zero). Accepts decoded instructions, stalls while a source register has an unretired write in flight, drives the register-file read and write ports, and delivers both operands one cycle after issue. A writeback landing in the same cycle as a read is forwarded. Sits between decode and execute; writeback feeds it directly.

## Interface
- CNT_W, 2: width of each per-register in-flight counter; MAX_INFLIGHT = 2^CNT_W - 1.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  instruction accepted this cycle when issue_valid && issue_ready.
- issue_rs1, issue_rs2  in  5  source register indices.
- issue_rd  in  5  destination index.
- issue_rd_we  in  1  instruction will write issue_rd.
- wb_valid  in  1  writeback retires a result this cycle.
- wb_rd  in  5  writeback destination.
- wb_val  in  32  writeback data.
- rf_rs1, rf_rs2  out  5  register-file read addresses (= issue_rs1/issue_rs2, combinational).
- rf_val_rs1, rf_val_rs2  in  32  register-file read data, valid one cycle after address.
- rf_rd  out  5  register-file write address (= wb_rd).
- rf_val_rd  out  32  register-file write data (= wb_val).
- rf_write_enable  out  1  wb_valid && wb_rd != 0.
- op_valid  out  1  one-cycle pulse: operands valid.
- op_a, op_b  out  32  operand values.
- op_rd  out  5  registered issue_rd.
- op_rd_we  out  1  registered issue_rd_we && issue_rd != 0.
- sb_err  out  1  sticky: writeback to a register with zero in-flight count.

## Operation
- Scoreboard: cnt[1..31], CNT_W bits each; x0 has no counter and is never pending.
- wb_hit(r): wb_valid && wb_rd == r && r != 0.
- Source r ready: r == 0, or cnt[r] == 0, or (cnt[r] == 1 && wb_hit(r)).
- Destination ready: !issue_rd_we, or issue_rd == 0, or cnt[rd] < MAX_INFLIGHT, or wb_hit(rd).
- issue_ready = !reset && rs1 ready && rs2 ready && destination ready. Combinational on the issue inputs, scoreboard state and wb inputs; does not depend on issue_valid.
- Counter update per register r each cycle: +1 if accept && issue_rd_we && issue_rd == r; -1 if wb_hit(r) && cnt[r] != 0; both → unchanged. wb_hit(r) with cnt[r] == 0 → counter stays 0, sb_err set; the write still reaches the register file.
- Forwarding: on accept, fwd_a <= wb_hit(issue_rs1), fwd_a_val <= wb_val (likewise for b). Next cycle op_a = fwd_a ? fwd_a_val : rf_val_rs1. The register file returns the pre-write value on a same-cycle read/write collision; this path covers it.
- x0 source: the register file returns 0; no forward (wb_hit excludes r = 0).
- No downstream backpressure: op_valid pulses for exactly one cycle per accepted instruction.

## Timing
- Accept at edge N → op_valid, op_a, op_b, op_rd, op_rd_we valid in cycle N+1; throughput 1 per cycle.
- No accept in cycle N → op_valid = 0 in N+1; op_a/op_b hold their previous values.
- Writeback ports pass through combinationally; the write commits at the same edge as the counter decrement.
- Reset (asynchronous, any time): all cnt = 0, op_valid = 0, op_a = op_b = 0, op_rd = 0, op_rd_we = 0, fwd flags = 0, sb_err = 0, issue_ready = 0 while reset is asserted. Writebacks after reset for instructions issued before reset set sb_err.

## Test plan
- Back-to-back independent: issue add x5←x1,x2 (x1=7, x2=9 preloaded), then x6←x3,x4 → op_a=7, op_b=9 at N+1; second at N+2; issue_ready stays 1.
- RAW stall: issue x5 write; next issue reads x5 → issue_ready=0 until wb_valid wb_rd=5 wb_val=0x1234; accepted in that cycle; op_a=0x1234 next cycle via forward.
- Saturation: three unretired writes to x7 → fourth write to x7 stalls; wb to x7 in the same cycle → accepted, cnt[7] stays 3.
- x0: issue rd=0 with rd_we=1 and rs1=0 → never stalls, op_a=0, op_rd_we=0; wb_rd=0 → rf_write_enable=0, sb_err unchanged.
- Spurious writeback: wb_rd=9 with cnt[9]=0 → rf_write_enable=1, sb_err=1 and stays 1 until reset.
- Reset mid-stall: pending x5, assert reset → issue_ready=0 and op_valid=0 immediately; after release, a read of x5 issues with no stall.
